// File: rtl/not16_serial_rx_if.sv
// not16_serial_rx_if: line, handshake and status signals of the 16-bit serial receiver.
//   master: receiver side (samples bit_en/line_in, drives out/out_valid/frame_err/overrun)
//   slave : line driver plus word consumer (drives bit_en/line_in/out_ready/clr_err)
interface not16_serial_rx_if;
    logic        bit_en;
    logic        line_in;
    logic [15:0] out;
    logic        out_valid;
    logic        out_ready;
    logic        frame_err;
    logic        overrun;
    logic        clr_err;
    modport master (
        input  bit_en, line_in, out_ready, clr_err,
        output out, out_valid, frame_err, overrun
    );
    modport slave (
        output bit_en, line_in, out_ready, clr_err,
        input  out, out_valid, frame_err, overrun
    );
endinterface

// File: rtl/not16_serial_rx.sv
// not16_serial_rx: receives start/16 data (LSB first)/stop frames and presents the word with a valid/ready handshake.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : master modport of not16_serial_rx_if (bit_en, line_in, out, out_valid, out_ready,
//           frame_err, overrun, clr_err)
//   INVERT: 1 = line carries the complement of the data word, 0 = true data
module not16_serial_rx #(
    parameter bit INVERT = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    not16_serial_rx_if.master  bus
);
    typedef enum logic [1:0] {IDLE, DATA, STOP} state_t;
    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] shift_q, shift_d;
    logic [15:0] out_q, out_d;
    logic        valid_q, valid_d;
    logic        ferr_q, ferr_d;
    logic        ovr_q, ovr_d;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        out_d   = out_q;
        valid_d = valid_q && !bus.out_ready;
        ferr_d  = ferr_q && !bus.clr_err;
        ovr_d   = ovr_q && !bus.clr_err;
        if (bus.bit_en) begin
            case (state_q)
                IDLE: begin
                    state_d = bus.line_in ? IDLE : DATA;
                    cnt_d   = 4'd0;
                end
                DATA: begin
                    shift_d[cnt_q] = bus.line_in;
                    cnt_d          = cnt_q + 4'd1;
                    state_d        = (cnt_q == 4'd15) ? STOP : DATA;
                end
                STOP: begin
                    state_d = IDLE;
                    out_d   = INVERT ? ~shift_q : shift_q;
                    valid_d = 1'b1;
                    // Set beats a coinciding clr_err.
                    ferr_d  = ferr_d || !bus.line_in;
                    // Only an unconsumed word being replaced counts as overrun.
                    ovr_d   = ovr_d || (valid_q && !bus.out_ready);
                end
                default: state_d = IDLE;
            endcase
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            shift_q <= 16'h0000;
            out_q   <= 16'h0000;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end
    assign bus.out       = out_q;
    assign bus.out_valid = valid_q;
    assign bus.frame_err = ferr_q;
    assign bus.overrun   = ovr_q;
endmodule

// File: doc/not16_serial_rx.md
NOT16_SERIAL_RX -- requirements
Module: not16_serial_rx

Interface
REQ-001 SHALL have parameter: INVERT, default 1, 1 = line carries bitwise complement of data word (undo with NOT), 0 = line carries true data.
REQ-002 SHALL have ports, one per line:
  clk        input   1   rising-edge clock, sole clock
  rst_n      input   1   reset, asynchronous assert, active-low
  bit_en     input   1   line sample strobe; one line bit per cycle where bit_en=1
  line_in    input   1   serial line, idles at 1
  out        output  16  recovered data word
  out_valid  output  1   out holds an unconsumed word
  out_ready  input   1   consumer accepts word when out_valid=1 and out_ready=1
  frame_err  output  1   sticky: stop bit sampled as 0
  overrun    output  1   sticky: word completed while previous word unconsumed
  clr_err    input   1   synchronous clear of frame_err and overrun
REQ-003 SHALL use one clock; reset is asynchronous and active-low (rst_n).

Function
REQ-004 Frame on line, sampled only when bit_en=1: start bit (0), 16 data bits LSB first, stop bit (1).
REQ-005 FSM states SHALL be IDLE, DATA, STOP; cycles with bit_en=0 SHALL hold all state.
REQ-006 IDLE: sample 0 -> DATA, bit counter=0; sample 1 -> stay IDLE.
REQ-007 DATA: each sample shifts into bit position counter (LSB first), counter increments; after 16th sample (counter 15) -> STOP.
REQ-008 STOP: sample 1 -> word complete; sample 0 -> word complete and frame_err set; both -> IDLE.
REQ-009 Word complete SHALL load out with shift register when INVERT=1 inverted bitwise (all 16 bits), else unmodified, and set out_valid, on the same edge that samples the stop bit.
REQ-010 Latency: out_valid SHALL rise on the clock edge sampling the stop bit (0 cycles after stop sample).
REQ-011 Handshake: out_valid=1 and out_ready=1 at an edge clears out_valid; out SHALL hold its value until next word complete.
REQ-012 out_valid=1 and out SHALL stay stable while out_ready=0.
REQ-013 Word complete while out_valid=1 and out_ready=0: overwrite out, keep out_valid=1, set overrun.
REQ-014 Word complete with out_valid=1 and out_ready=1 same edge: load new word, out_valid stays 1, no overrun.
REQ-015 A frame with frame_err SHALL still deliver its word.
REQ-016 clr_err=1 clears both sticky flags; if a set event coincides, set wins.
REQ-017 Back-to-back frames (stop then immediate start on next bit_en) SHALL be received without loss.
REQ-018 out_ready while out_valid=0 SHALL have no effect.

Reset
REQ-019 rst_n=0 SHALL immediately force: state IDLE, counter 0, shift register 0, out=16'h0000, out_valid=0, frame_err=0, overrun=0.
REQ-020 Reset mid-frame SHALL discard partial word; after release a new start bit is required.
REQ-021 Release of rst_n SHALL take effect on next clk edge; no output change until a frame completes.

Verification
REQ-022 INVERT=1, frame line bits = ~16'h00FF LSB first, stop 1, out_ready=1 -> out=16'h00FF, out_valid pulses one cycle, no flags.
REQ-023 INVERT=1, line data 16'hAAAA -> out=16'h5555; then 16'h0000 -> out=16'hFFFF; then 16'hC3C3 -> out=16'h3C3C, back-to-back frames, bit_en=1 every cycle.
REQ-024 out_ready=0, two frames 16'h1234 then 16'hABCD (post-inversion) -> out=16'hABCD, out_valid=1, overrun=1; clr_err -> overrun=0, out_valid still 1.
REQ-025 Stop bit 0, data giving 16'hED12 -> out=16'hED12 delivered, frame_err=1, stays 1 until clr_err.
REQ-026 rst_n low after 8 data bits, release, full frame 16'h0F0F -> only 16'h0F0F delivered, no flags.
REQ-027 bit_en toggling 1-in-3 cycles, INVERT=0, frame 16'h8001 -> out=16'h8001, state held during bit_en=0.
